fifo_stream_reader: RTL

Read-side engine for `synchronous_fifo`. It drains the FIFO by driving `rd_en` against `empty`, absorbs the FIFO's one-cycle read latency, and presents words on a valid/ready stream with full backpressure. A 2-entry skid buffer sustains one word per cycle. The block sits between the FIFO's read port and any downstream consumer, and keeps a running count of delivered words.

---
 rtl/fifo_rd_pkg.sv | 24 ++
 rtl/fifo_stream_reader_chk.sv | 20 ++
 rtl/skid_buf2.sv | 89 ++++++++
 rtl/fifo_stream_reader.sv | 89 ++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   localparam int SKID_DEPTH = 2;

   // Numeric word count held by the skid buffer, widened for credit arithmetic.
   function automatic logic [2:0] occ_count(input occ_t occ);
      logic [2:0] n;
      case (occ)
         OCC_EMPTY: n = 3'd0;
         OCC_ONE:   n = 3'd1;
         OCC_TWO:   n = 3'd2;
         default:   n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_chk.sv
// Protocol checks for the read engine: credit rule must never overfill the skid buffer.
module fifo_stream_reader_chk
   import fifo_rd_pkg::*;
(
   input logic clk,
   input logic rst_n,
   input occ_t occ,
   input logic push,
   input logic pop,
   input logic rd_en,
   input logic empty
);

   a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
      !(occ == OCC_TWO && push && !pop));

   a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_en && empty));

endmodule

// File: rtl/skid_buf2.sv
// Two-entry skid buffer; head register drives the stream data directly.
module skid_buf2
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output occ_t                  occ
);

   occ_t                  occ_q, occ_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;

   // Next-state for occupancy and the two data slots; head only moves on pop or first fill.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (push) begin
                  head_d = din;
                  occ_d  = OCC_ONE;
               end else begin
                  occ_d = OCC_EMPTY;
               end
            end
            OCC_ONE: begin
               if (push && pop) begin
                  head_d = din;
               end else if (push) begin
                  tail_d = din;
                  occ_d  = OCC_TWO;
               end else if (pop) begin
                  occ_d = OCC_EMPTY;
               end else begin
                  occ_d = OCC_ONE;
               end
            end
            OCC_TWO: begin
               if (pop) begin
                  head_d = tail_q;
                  if (push) begin
                     tail_d = din;
                  end else begin
                     occ_d = OCC_ONE;
                  end
               end else begin
                  occ_d = OCC_TWO;
               end
            end
            default: occ_d = OCC_EMPTY;
         endcase
      end
      valid_d = (occ_d != OCC_EMPTY);
   end

   // Buffer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q   <= OCC_EMPTY;
         valid_q <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         occ_q   <= occ_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign dout  = head_q;
   assign valid = valid_q;
   assign occ   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains synchronous_fifo onto a valid/ready stream with credit-based read issue.
module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_en,
   input  logic                  enable,
   input  logic                  flush,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   occ_t                 occ;
   logic                 pop;
   logic                 rd_ok;
   logic [2:0]           credit;
   logic                 inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

   assign pop = m_valid && m_ready;

   // Words already committed (buffered + in flight) after this cycle's pop must leave room.
   always_comb begin
      credit = occ_count(occ) + {2'b00, inflight_q} - {2'b00, pop};
      if (enable && !flush && !empty && (credit < 3'(SKID_DEPTH))) begin
         rd_ok = 1'b1;
      end else begin
         rd_ok = 1'b0;
      end
   end

   assign rd_en = rd_ok && rst_n;

   // A flushed cycle never issues a read, so the in-flight flag clears with it.
   always_comb begin
      inflight_d = rd_ok;
      if (pop) begin
         word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         word_cnt_d = word_cnt_q;
      end
   end

   // Read-tracking and delivered-word counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         inflight_q <= inflight_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   skid_buf2 #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight_q),
      .pop   (pop),
      .flush (flush),
      .din   (data_out),
      .dout  (m_data),
      .valid (m_valid),
      .occ   (occ)
   );

   fifo_stream_reader_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .occ   (occ),
      .push  (inflight_q),
      .pop   (pop),
      .rd_en (rd_en),
      .empty (empty)
   );

   assign word_cnt = word_cnt_q;

endmodule
